// File: rtl/uart_tx_arbiter.sv
// Two-requester byte arbiter in front of a single UART transmitter.
// Round-robin at packet boundaries, grant held for a whole packet, strobes paced by byte time.
module uart_tx_arbiter #(
   parameter int unsigned CLOCKFRQ     = 240000000,
   parameter int unsigned BAUDRATE     = 3500000,
   parameter int unsigned BYTE_CYCLES  = (CLOCKFRQ / (BAUDRATE * 4)) * 44 + 4,
   parameter int unsigned LOCK_TIMEOUT = 65535
) (
   input  logic       clk,
   input  logic       nRst,
   input  logic       req0_valid,
   input  logic [7:0] req0_data,
   input  logic       req0_last,
   output logic       req0_ready,
   input  logic       req1_valid,
   input  logic [7:0] req1_data,
   input  logic       req1_last,
   output logic       req1_ready,
   output logic       transmit,
   output logic [7:0] tx_byte,
   output logic       grant,
   output logic       locked,
   output logic       busy,
   output logic       lock_err
);

   localparam int unsigned PW = $clog2(BYTE_CYCLES) + 1;
   localparam int unsigned TW = ($clog2(LOCK_TIMEOUT + 1) > 16) ? $clog2(LOCK_TIMEOUT + 1) : 16;
   localparam logic [PW-1:0] PaceLoad = PW'(BYTE_CYCLES - 2);
   localparam logic [TW-1:0] ToLimit  = TW'(LOCK_TIMEOUT);

   typedef enum logic [1:0] {StArb, StSend, StWait} state_t;

   state_t        state_q;
   logic [PW-1:0] pace_q;
   logic [TW-1:0] to_cnt_q;
   logic          last_grant_q;

   logic       elig0, elig1, sel, in_arb, accept, acc_last, idle_locked, to_expire;
   logic [7:0] acc_data;

   always_comb begin
      elig0       = req0_valid && (!locked || !grant);
      elig1       = req1_valid && (!locked || grant);
      sel         = (elig0 && elig1) ? ~last_grant_q : elig1;
      // Gate with nRst so a reset edge never coincides with a handshake
      in_arb      = nRst && (state_q == StArb);
      req0_ready  = in_arb && elig0 && !sel;
      req1_ready  = in_arb && elig1 && sel;
      accept      = req0_ready || req1_ready;
      acc_data    = sel ? req1_data : req0_data;
      acc_last    = sel ? req1_last : req0_last;
      idle_locked = (state_q == StArb) && locked && !(grant ? req1_valid : req0_valid);
      to_expire   = (LOCK_TIMEOUT != 0) && idle_locked && ((to_cnt_q + TW'(1)) == ToLimit);
   end

   assign busy = (state_q != StArb);

   always_ff @(posedge clk) begin
      if (!nRst) begin
         state_q      <= StArb;
         pace_q       <= '0;
         to_cnt_q     <= '0;
         last_grant_q <= 1'b1;
         transmit     <= 1'b0;
         tx_byte      <= 8'h00;
         grant        <= 1'b0;
         locked       <= 1'b0;
         lock_err     <= 1'b0;
      end else begin
         transmit <= 1'b0;
         lock_err <= 1'b0;
         unique case (state_q)
            StArb: begin
               if (accept) begin
                  tx_byte      <= acc_data;
                  grant        <= sel;
                  last_grant_q <= sel;
                  locked       <= ~acc_last;
                  to_cnt_q     <= '0;
                  transmit     <= 1'b1;
                  state_q      <= StSend;
               end else if (to_expire) begin
                  locked   <= 1'b0;
                  lock_err <= 1'b1;
                  to_cnt_q <= '0;
               end else if (idle_locked && (to_cnt_q != '1)) begin
                  to_cnt_q <= to_cnt_q + TW'(1);
               end
            end
            StSend: begin
               pace_q  <= PaceLoad;
               state_q <= (BYTE_CYCLES > 2) ? StWait : StArb;
            end
            StWait: begin
               if (pace_q != '0) pace_q <= pace_q - PW'(1);
               // Leave on the cycle the count reaches zero so accept spacing is BYTE_CYCLES
               if (pace_q <= PW'(1)) state_q <= StArb;
            end
            default: state_q <= StArb;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed scenarios plus randomized two-stream traffic
// checked against a packet-level model of ordering, pacing and round-robin.
module tb_uart_tx_arbiter;

   localparam int unsigned BC = 8;
   localparam int unsigned LT = 20;

   logic       clk = 1'b0;
   logic       nRst;
   logic       req0_valid, req0_last, req0_ready;
   logic [7:0] req0_data;
   logic       req1_valid, req1_last, req1_ready;
   logic [7:0] req1_data;
   logic       transmit, grant, locked, busy, lock_err;
   logic [7:0] tx_byte;

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   uart_tx_arbiter #(
      .CLOCKFRQ(240000000),
      .BAUDRATE(3500000),
      .BYTE_CYCLES(BC),
      .LOCK_TIMEOUT(LT)
   ) dut (
      .clk(clk),
      .nRst(nRst),
      .req0_valid(req0_valid),
      .req0_data(req0_data),
      .req0_last(req0_last),
      .req0_ready(req0_ready),
      .req1_valid(req1_valid),
      .req1_data(req1_data),
      .req1_last(req1_last),
      .req1_ready(req1_ready),
      .transmit(transmit),
      .tx_byte(tx_byte),
      .grant(grant),
      .locked(locked),
      .busy(busy),
      .lock_err(lock_err)
   );

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      nRst = 1'b0;
      req0_valid = 1'b0; req0_data = 8'h00; req0_last = 1'b0;
      req1_valid = 1'b0; req1_data = 8'h00; req1_last = 1'b0;
      cyc();
      cyc();
      nRst = 1'b1;
   endtask

   task automatic test_reset();
      nRst = 1'b0;
      req0_valid = 1'b1; req0_data = 8'h77; req0_last = 1'b1;
      req1_valid = 1'b0; req1_data = 8'h00; req1_last = 1'b0;
      for (int i = 0; i < 2; i++) begin
         cyc();
         @(negedge clk);
         vectors++;
         if ({req0_ready, req1_ready, transmit, tx_byte, grant, locked, lock_err, busy} !== 14'h0) begin
            miscompares++;
            $display("FAIL reset_state: got rdy=%b%b tx=%b byte=%h g=%b l=%b e=%b b=%b expected all 0",
                     req0_ready, req1_ready, transmit, tx_byte, grant, locked, lock_err, busy);
         end
      end
      cyc();
      nRst = 1'b1;
      req0_valid = 1'b0;
      @(negedge clk);
      vectors++;
      if (transmit !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_no_strobe: got transmit=%b expected 0", transmit);
      end
   endtask

   task automatic test_single();
      apply_reset();
      for (int i = 0; i < 10; i++) cyc();
      req0_valid = 1'b1; req0_data = 8'hA5; req0_last = 1'b1;
      @(negedge clk);
      vectors++;
      if (req0_ready !== 1'b1 || busy !== 1'b0) begin
         miscompares++;
         $display("FAIL single_ready: got ready=%b busy=%b expected 1 0", req0_ready, busy);
      end
      cyc();
      req0_valid = 1'b0;
      @(negedge clk);
      vectors++;
      if (transmit !== 1'b1 || tx_byte !== 8'hA5 || busy !== 1'b1 || locked !== 1'b0) begin
         miscompares++;
         $display("FAIL single_strobe: got tx=%b byte=%h busy=%b locked=%b expected 1 a5 1 0",
                  transmit, tx_byte, busy, locked);
      end
      for (int c = 12; c <= 28; c++) begin
         cyc();
         @(negedge clk);
         vectors++;
         if (busy !== (c <= 17) || transmit !== 1'b0 || tx_byte !== 8'hA5) begin
            miscompares++;
            $display("FAIL single_pace c=%0d: got busy=%b tx=%b byte=%h expected %b 0 a5",
                     c, busy, transmit, tx_byte, (c <= 17));
         end
      end
   endtask

   task automatic test_round_robin();
      int strobes;
      int last_c;
      logic [7:0] exp;
      strobes = 0;
      last_c = 0;
      apply_reset();
      req0_valid = 1'b1; req0_data = 8'h11; req0_last = 1'b1;
      req1_valid = 1'b1; req1_data = 8'h22; req1_last = 1'b1;
      for (int c = 0; c < 50; c++) begin
         @(negedge clk);
         if (transmit === 1'b1) begin
            exp = (strobes % 2 == 0) ? 8'h11 : 8'h22;
            vectors++;
            if (tx_byte !== exp) begin
               miscompares++;
               $display("FAIL rr_byte #%0d: got %h expected %h", strobes, tx_byte, exp);
            end
            if (strobes > 0) begin
               vectors++;
               if (c - last_c != int'(BC)) begin
                  miscompares++;
                  $display("FAIL rr_spacing: got %0d expected %0d", c - last_c, BC);
               end
            end
            last_c = c;
            strobes++;
         end
         cyc();
      end
      vectors++;
      if (strobes != 7) begin
         miscompares++;
         $display("FAIL rr_count: got %0d expected 7", strobes);
      end
   endtask

   task automatic test_locked_packet();
      logic [7:0] pkt[3];
      logic [7:0] exp[4];
      int acc0, acc1, ns;
      bit hs0, hs1;
      pkt = '{8'h01, 8'h02, 8'h03};
      exp = '{8'h01, 8'h02, 8'h03, 8'h22};
      acc0 = 0; acc1 = 0; ns = 0;
      apply_reset();
      for (int c = 0; c < 40; c++) begin
         req0_valid = (acc0 < 3);
         req0_data  = pkt[(acc0 < 3) ? acc0 : 2];
         req0_last  = (acc0 == 2);
         req1_valid = (acc1 == 0); req1_data = 8'h22; req1_last = 1'b1;
         @(negedge clk);
         vectors++;
         if (locked !== (acc0 == 1 || acc0 == 2)) begin
            miscompares++;
            $display("FAIL lock_flag c=%0d: got %b expected %b", c, locked, (acc0 == 1 || acc0 == 2));
         end
         if (acc0 < 3) begin
            vectors++;
            if (req1_ready !== 1'b0) begin
               miscompares++;
               $display("FAIL lock_hold c=%0d: got req1_ready=%b expected 0", c, req1_ready);
            end
         end
         if (transmit === 1'b1) begin
            vectors++;
            if (ns > 3 || tx_byte !== exp[(ns > 3) ? 3 : ns]) begin
               miscompares++;
               $display("FAIL lock_seq #%0d: got %h expected %h", ns, tx_byte, exp[(ns > 3) ? 3 : ns]);
            end
            ns++;
         end
         hs0 = req0_valid && req0_ready;
         hs1 = req1_valid && req1_ready;
         cyc();
         if (hs0) acc0++;
         if (hs1) acc1++;
      end
      vectors++;
      if (ns != 4) begin
         miscompares++;
         $display("FAIL lock_count: got %0d strobes expected 4", ns);
      end
   endtask

   task automatic test_lock_timeout();
      apply_reset();
      req0_valid = 1'b1; req0_data = 8'h01; req0_last = 1'b0;
      @(negedge clk);
      vectors++;
      if (req0_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL to_first: got req0_ready=%b expected 1", req0_ready);
      end
      cyc();
      req0_valid = 1'b0;
      req1_valid = 1'b1; req1_data = 8'h22; req1_last = 1'b1;
      for (int c = 1; c <= 34; c++) begin
         @(negedge clk);
         vectors++;
         if (lock_err !== (c == 8 + int'(LT)) || locked !== (c < 8 + int'(LT))
             || req1_ready !== (c == 8 + int'(LT))) begin
            miscompares++;
            $display("FAIL lock_timeout c=%0d: got err=%b locked=%b rdy1=%b expected %b %b %b", c,
                     lock_err, locked, req1_ready, (c == 8 + int'(LT)), (c < 8 + int'(LT)),
                     (c == 8 + int'(LT)));
         end
         if (c == 9 + int'(LT)) begin
            vectors++;
            if (transmit !== 1'b1 || tx_byte !== 8'h22 || grant !== 1'b1) begin
               miscompares++;
               $display("FAIL to_resume: got tx=%b byte=%h grant=%b expected 1 22 1",
                        transmit, tx_byte, grant);
            end
         end
         cyc();
         if (c == 8 + int'(LT)) req1_valid = 1'b0;
      end
   endtask

   task automatic test_reset_in_wait();
      apply_reset();
      req1_valid = 1'b1; req1_data = 8'h09; req1_last = 1'b0;
      cyc();
      req1_valid = 1'b0;
      for (int i = 0; i < 3; i++) cyc();
      @(negedge clk);
      vectors++;
      if (busy !== 1'b1 || locked !== 1'b1 || grant !== 1'b1) begin
         miscompares++;
         $display("FAIL rw_pre: got busy=%b locked=%b grant=%b expected 1 1 1", busy, locked, grant);
      end
      cyc();
      nRst = 1'b0;
      cyc();
      nRst = 1'b1;
      req0_valid = 1'b1; req0_data = 8'h33; req0_last = 1'b1;
      req1_valid = 1'b1; req1_data = 8'h44; req1_last = 1'b1;
      @(negedge clk);
      vectors++;
      if (transmit !== 1'b0 || locked !== 1'b0 || grant !== 1'b0 || busy !== 1'b0
          || req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
         miscompares++;
         $display("FAIL rw_post: got tx=%b l=%b g=%b b=%b rdy=%b%b expected 0 0 0 0 rdy=01",
                  transmit, locked, grant, busy, req1_ready, req0_ready);
      end
      cyc();
      req0_valid = 1'b0; req1_valid = 1'b0;
      @(negedge clk);
      vectors++;
      if (transmit !== 1'b1 || tx_byte !== 8'h33) begin
         miscompares++;
         $display("FAIL rw_first: got tx=%b byte=%h expected 1 33", transmit, tx_byte);
      end
   endtask

   task automatic test_valid_pulse();
      apply_reset();
      req0_valid = 1'b1; req0_data = 8'h5A; req0_last = 1'b1;
      cyc();
      for (int c = 1; c <= 14; c++) begin
         req0_valid = (c <= 6) ? 1'($urandom_range(0, 1)) : 1'b0;
         req1_valid = (c <= 6) ? 1'($urandom_range(0, 1)) : 1'b0;
         req0_data = 8'($urandom); req1_data = 8'($urandom);
         req0_last = 1'($urandom_range(0, 1)); req1_last = 1'($urandom_range(0, 1));
         @(negedge clk);
         vectors++;
         if (req0_ready !== 1'b0 || req1_ready !== 1'b0 || transmit !== (c == 1)
             || tx_byte !== 8'h5A) begin
            miscompares++;
            $display("FAIL pulse c=%0d: got rdy=%b%b tx=%b byte=%h expected rdy=00 tx=%b byte=5a",
                     c, req1_ready, req0_ready, transmit, tx_byte, (c == 1));
         end
         cyc();
      end
   endtask

   task automatic test_random();
      logic [7:0] d0[64], d1[64];
      bit l0[64], l1[64];
      int n0, n1, i0, i1, g0, g1, len, owner, last_win, last_hs, cn;
      bit in_pkt, pend, hs0, hs1;
      logic [7:0] pend_byte;
      n0 = 0; n1 = 0;
      while (n0 < 30) begin
         len = $urandom_range(1, 4);
         for (int k = 0; k < len; k++) begin
            d0[n0] = 8'($urandom_range(0, 127)); l0[n0] = (k == len - 1); n0++;
         end
      end
      while (n1 < 30) begin
         len = $urandom_range(1, 4);
         for (int k = 0; k < len; k++) begin
            d1[n1] = 8'($urandom_range(128, 255)); l1[n1] = (k == len - 1); n1++;
         end
      end
      apply_reset();
      i0 = 0; i1 = 0; g0 = $urandom_range(0, 3); g1 = $urandom_range(0, 3);
      owner = 0; last_win = 1; last_hs = -100; in_pkt = 0; pend = 0; hs0 = 0; hs1 = 0;
      pend_byte = 8'h00;
      for (cn = 0; cn < 4000 && !(i0 == n0 && i1 == n1 && !pend); cn++) begin
         if (hs0) begin i0++; g0 = l0[i0-1] ? $urandom_range(0, 15) : $urandom_range(0, 4); end
         if (hs1) begin i1++; g1 = l1[i1-1] ? $urandom_range(0, 15) : $urandom_range(0, 4); end
         if (g0 > 0) begin req0_valid = 1'b0; g0--; end
         else if (i0 < n0) begin
            req0_valid = !((i0 == 0 || l0[(i0 > 0) ? i0 - 1 : 0]) && $urandom_range(0, 9) == 0);
            req0_data = d0[i0]; req0_last = l0[i0];
         end else req0_valid = 1'b0;
         if (g1 > 0) begin req1_valid = 1'b0; g1--; end
         else if (i1 < n1) begin
            req1_valid = !((i1 == 0 || l1[(i1 > 0) ? i1 - 1 : 0]) && $urandom_range(0, 9) == 0);
            req1_data = d1[i1]; req1_last = l1[i1];
         end else req1_valid = 1'b0;
         @(negedge clk);
         vectors++;
         if ((req0_ready && req1_ready) || (req0_ready && !req0_valid)
             || (req1_ready && !req1_valid) || lock_err !== 1'b0) begin
            miscompares++;
            $display("FAIL rnd_handshake cyc=%0d: got rdy=%b%b vld=%b%b err=%b expected legal",
                     cn, req1_ready, req0_ready, req1_valid, req0_valid, lock_err);
         end
         vectors++;
         if (transmit !== pend || (pend && tx_byte !== pend_byte)) begin
            miscompares++;
            $display("FAIL rnd_strobe cyc=%0d: got tx=%b byte=%h expected tx=%b byte=%h",
                     cn, transmit, tx_byte, pend, pend_byte);
         end
         hs0 = req0_valid && req0_ready;
         hs1 = req1_valid && req1_ready;
         pend = hs0 || hs1;
         pend_byte = hs0 ? d0[i0] : d1[(i1 < n1) ? i1 : 0];
         if (pend) begin
            vectors++;
            if (cn - last_hs < int'(BC)) begin
               miscompares++;
               $display("FAIL rnd_spacing: got %0d expected >= %0d", cn - last_hs, BC);
            end
            vectors++;
            if (in_pkt && owner != int'(hs1)) begin
               miscompares++;
               $display("FAIL rnd_interleave: got req%0d expected req%0d", int'(hs1), owner);
            end
            if (!in_pkt && req0_valid && req1_valid) begin
               vectors++;
               if (hs1 !== (last_win == 0)) begin
                  miscompares++;
                  $display("FAIL rnd_rr: got req%0d expected req%0d", int'(hs1), 1 - last_win);
               end
            end
            last_hs = cn;
            owner = int'(hs1);
            last_win = int'(hs1);
            in_pkt = hs0 ? !l0[i0] : !l1[(i1 < n1) ? i1 : 0];
         end
         cyc();
      end
      vectors++;
      if (i0 != n0 || i1 != n1) begin
         miscompares++;
         $display("FAIL rnd_drain: got %0d/%0d and %0d/%0d bytes expected all", i0, n0, i1, n1);
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_single();
      test_round_robin();
      test_locked_packet();
      test_lock_timeout();
      test_reset_in_wait();
      test_valid_pulse();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
